// File: rtl/dram_responder.sv
// Word-addressed DRAM stand-in for the layer engines: write-first single-port-style
// storage with a fixed-latency read pipeline, access counters and a sticky range error.
module dram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int MEM_WORDS  = 262144,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dram_en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  dram_en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dram_valid,
    output logic                  err_oob,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic             rd_in_range;
    logic             wr_in_range;
    logic             wr_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] cap_data;

    logic [RD_LAT-1:0]     vld_q;
    logic [RD_LAT-1:0]     vld_d;
    logic [DATA_WIDTH-1:0] data_q [RD_LAT];
    logic [DATA_WIDTH-1:0] data_d [RD_LAT];
    logic [31:0]           rd_cnt_q;
    logic [31:0]           rd_cnt_d;
    logic [31:0]           wr_cnt_q;
    logic [31:0]           wr_cnt_d;
    logic                  err_oob_q;
    logic                  err_oob_d;

    assign rd_in_range = ({1'b0, addr_in} < MEM_LIMIT);
    assign wr_in_range = ({1'b0, addr_out} < MEM_LIMIT);
    assign wr_ok       = dram_en_wr && wr_in_range;
    assign rd_idx      = IDX_W'(addr_in);
    assign wr_idx      = IDX_W'(addr_out);

    // Storage is deliberately outside the reset domain; only the write enable sees rst.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        cap_data = '0;
        if (rd_in_range) begin
            if (wr_ok && (addr_out == addr_in)) begin
                cap_data = wr_data;
            end else begin
                cap_data = mem[rd_idx];
            end
        end
    end

    // Data words only move with their valid bit, so the last stage holds the previous response.
    always_comb begin
        vld_d     = '0;
        vld_d[0]  = dram_en_rd;
        data_d[0] = dram_en_rd ? cap_data : data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
        rd_cnt_d  = rd_cnt_q + 32'(dram_en_rd);
        wr_cnt_d  = wr_cnt_q + 32'(dram_en_wr);
        err_oob_d = err_oob_q
                  | (dram_en_rd && !rd_in_range)
                  | (dram_en_wr && !wr_in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_oob_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_oob_q <= err_oob_d;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rd_data    = data_q[RD_LAT-1];
    assign dram_valid = vld_q[RD_LAT-1];
    assign err_oob    = err_oob_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: three instances (latency 1, latency 3, and a
// 1024-word latency-4 variant) share one stimulus stream.
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_rd = 1'b0;
    logic        en_wr = 1'b0;
    logic [17:0] a_in = '0;
    logic [17:0] a_out = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rd1, rd3, rd4;
    logic        valid1, valid3, valid4;
    logic        err1, err3, err4;
    logic [31:0] rdc1, rdc3, rdc4;
    logic [31:0] wrc1, wrc3, wrc4;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount;

    always #5 clk = ~clk;

    dram_responder #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .dram_en_rd(en_rd), .addr_in(a_in),
        .dram_en_wr(en_wr), .addr_out(a_out), .wr_data(wdata),
        .rd_data(rd1), .dram_valid(valid1), .err_oob(err1),
        .rd_cnt(rdc1), .wr_cnt(wrc1)
    );

    dram_responder #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .dram_en_rd(en_rd), .addr_in(a_in),
        .dram_en_wr(en_wr), .addr_out(a_out), .wr_data(wdata),
        .rd_data(rd3), .dram_valid(valid3), .err_oob(err3),
        .rd_cnt(rdc3), .wr_cnt(wrc3)
    );

    dram_responder #(.RD_LAT(4), .MEM_WORDS(1024)) dut4 (
        .clk(clk), .rst(rst), .dram_en_rd(en_rd), .addr_in(a_in),
        .dram_en_wr(en_wr), .addr_out(a_out), .wr_data(wdata),
        .rd_data(rd4), .dram_valid(valid4), .err_oob(err4),
        .rd_cnt(rdc4), .wr_cnt(wrc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b1;
        step();
        step();
        check("rst_rd_data", rd1, 32'h0);
        check("rst_valid", 32'(valid1), 32'h0);
        check("rst_err", 32'(err1), 32'h0);
        check("rst_rd_cnt", rdc1, 32'h0);
        check("rst_wr_cnt", wrc1, 32'h0);
        rst = 1'b0;

        // Write then read, latency 1
        en_wr = 1'b1; a_out = 18'hF040; wdata = 32'hDEADBEEF;
        step();
        en_wr = 1'b0;
        step();
        en_rd = 1'b1; a_in = 18'hF040;
        step();
        check("wr_rd_valid", 32'(valid1), 32'h1);
        check("wr_rd_data", rd1, 32'hDEADBEEF);
        check("wr_rd_wr_cnt", wrc1, 32'h1);
        check("wr_rd_rd_cnt", rdc1, 32'h1);
        en_rd = 1'b0;
        step();
        check("hold_valid", 32'(valid1), 32'h0);
        check("hold_data", rd1, 32'hDEADBEEF);

        // Same-cycle bypass and frozen in-flight data
        en_wr = 1'b1; a_out = 18'd5; wdata = 32'd7;
        step();
        en_wr = 1'b0; en_rd = 1'b1; a_in = 18'd5;
        step();
        check("pre_bypass_data", rd1, 32'd7);
        en_wr = 1'b1; a_out = 18'd5; wdata = 32'd9;
        step();
        check("bypass_data", rd1, 32'd9);
        check("bypass_valid", 32'(valid1), 32'h1);
        en_wr = 1'b0; en_rd = 1'b0;
        step();
        check("lat3_frozen_valid", 32'(valid3), 32'h1);
        check("lat3_frozen_data", rd3, 32'd7);
        step();
        check("lat3_bypass_data", rd3, 32'd9);

        // Streaming, latency 3
        for (int i = 0; i < 16; i++) begin
            en_wr = 1'b1; a_out = 18'h20000 + 18'(i); wdata = 32'(i);
            step();
        end
        en_wr = 1'b0;
        vcount = 0;
        for (int c = 0; c < 22; c++) begin
            en_rd = (c < 16);
            a_in  = 18'h20000 + 18'(c);
            step();
            check($sformatf("stream_valid_%0d", c), 32'(valid3), 32'((c >= 2) && (c < 18)));
            if (valid3) begin
                vcount++;
                check($sformatf("stream_data_%0d", c), rd3, 32'(c - 2));
            end
        end
        en_rd = 1'b0;
        check("stream_count", 32'(vcount), 32'd16);

        // Asynchronous reset between edges, contents preserved
        #3 rst = 1'b1;
        #1;
        check("arst_rd_data", rd1, 32'h0);
        check("arst_rd_data3", rd3, 32'h0);
        check("arst_rd_cnt", rdc1, 32'h0);
        check("arst_wr_cnt", wrc1, 32'h0);
        check("arst_err4", 32'(err4), 32'h0);
        step();
        rst = 1'b0;
        en_rd = 1'b1; a_in = 18'd5;
        step();
        en_rd = 1'b0;
        check("preserve_data", rd1, 32'd9);

        // Out of range on the 1024-word instance
        en_wr = 1'b1; a_out = 18'd976; wdata = 32'h00000BAD;
        step();
        en_wr = 1'b0; en_rd = 1'b1; a_in = 18'd976;
        step();
        check("oob_err_before", 32'(err4), 32'h0);
        a_in = 18'd1024;
        step();
        check("oob_err_set", 32'(err4), 32'h1);
        en_rd = 1'b0; en_wr = 1'b1; a_out = 18'd2000; wdata = 32'h00001234;
        step();
        check("oob_wr_cnt", wrc4, 32'd2);
        en_wr = 1'b0; en_rd = 1'b1; a_in = 18'd976;
        step();
        en_rd = 1'b0;
        check("oob_inrange_valid", 32'(valid4), 32'h1);
        check("oob_inrange_data", rd4, 32'h00000BAD);
        step();
        check("oob_rd_valid", 32'(valid4), 32'h1);
        check("oob_rd_data", rd4, 32'h0);
        step();
        check("oob_gap_valid", 32'(valid4), 32'h0);
        step();
        check("oob_untouched", rd4, 32'h00000BAD);
        check("oob_err_sticky", 32'(err4), 32'h1);
        check("oob_rd_cnt", rdc4, 32'd4);

        // Mid-burst reset, latency 4
        vcount = 0;
        en_rd = 1'b1; a_in = 18'd976;
        step();
        vcount += 32'(valid4);
        step();
        vcount += 32'(valid4);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid4), 32'h0);
        step();
        vcount += 32'(valid4);
        step();
        vcount += 32'(valid4);
        rst = 1'b0; en_rd = 1'b0;
        check("mid_rst_rd_cnt", rdc4, 32'h0);
        check("mid_rst_wr_cnt", wrc4, 32'h0);
        check("mid_rst_err", 32'(err4), 32'h0);
        for (int c = 0; c < 10; c++) begin
            step();
            vcount += 32'(valid4);
        end
        check("mid_rst_no_pulse", 32'(vcount), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the layer engines' DRAM port: accepts single-word read and write requests issued by a compute engine (ReLU, conv, pool) and returns read data with a fixed, parameterised latency plus a `dram_valid` strobe. It sits between an engine's `addr_in`/`addr_out`/`dram_en_rd`/`dram_en_wr` outputs and a word-addressed storage array. It serves as the behavioural-plus-synthesizable DRAM stand-in for block and system simulation, and it maps the parameter, bias and feature-map regions into one flat address space.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 18, word address width.
- `MEM_WORDS`, 262144, implemented words; addresses at or above this are out of range.
- `RD_LAT`, 1, read latency in cycles; legal range 1..8.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dram_en_rd` in 1: read request, one word per cycle.
- `addr_in` in ADDR_WIDTH: read address, sampled when `dram_en_rd`=1.
- `dram_en_wr` in 1: write request.
- `addr_out` in ADDR_WIDTH: write address, sampled when `dram_en_wr`=1.
- `wr_data` in DATA_WIDTH: write data; this is the engine's `data_out`.
- `rd_data` out DATA_WIDTH: read data; this is the engine's `data_in`.
- `dram_valid` out 1: `rd_data` holds the response to a request.
- `err_oob` out 1: sticky flag for an out-of-range access.
- `rd_cnt` out 32: reads accepted since reset, wraps at 2^32.
- `wr_cnt` out 32: writes accepted since reset, wraps at 2^32.

## Operation
- Storage is `MEM_WORDS` x `DATA_WIDTH`. Contents are not cleared by `rst`; they are preserved across reset.
- Read and write are independent. One read and one write may be accepted in the same cycle.
- **Write:**
  - At the edge where `dram_en_wr`=1 and `addr_out`<`MEM_WORDS`, `mem[addr_out]` <= `wr_data`.
  - Otherwise nothing is stored.
- **Read issue:**
  - At the edge where `dram_en_rd`=1, the word is captured into pipeline stage 1.
  - If a write to the same address is accepted at that same edge, the captured word is `wr_data` (write-first bypass).
  - If the address is out of range, the captured word is 0.
- **Read pipeline:**
  - `RD_LAT` stages, each holding a valid bit and a data word.
  - The captured value is frozen at issue. Writes accepted after issue never alter an in-flight response.
  - Stages advance every cycle. There is no back-pressure; the engine must consume `rd_data` in the cycle `dram_valid`=1.
- **Output:**
  - `rd_data`/`dram_valid` are driven from the last stage.
  - When the last stage is not valid, `rd_data` holds its previous value and `dram_valid`=0.
- **Counters:** `rd_cnt`+1 per accepted read and `wr_cnt`+1 per accepted write, including out-of-range ones.
- **err_oob:** set at the edge of any read or write with address >= `MEM_WORDS`. Cleared only by `rst`.
- No state machine beyond the pipeline valid chain. The block is always ready; there is no idle or busy distinction.

## Timing
- Reset values: `rd_data`=0, `dram_valid`=0, `err_oob`=0, `rd_cnt`=0, `wr_cnt`=0, all pipeline valids=0.
- Read request sampled at edge t → `dram_valid`=1 and `rd_data` valid in the cycle following edge t+`RD_LAT`-1.
  - With `RD_LAT`=1, data appears in the cycle after the request. This matches engines that register `addr_out` <= `addr_in` and expect `data_in` one cycle later.
- Throughput: one read and one write per cycle, sustained indefinitely.
- Write visibility:
  - A write at edge t is visible to a read sampled at edge t (via bypass) and at any later edge.
  - A read sampled at edge t-1 returns the old data.
- `rst` asserted mid-burst: all in-flight responses are discarded immediately (asynchronously). `dram_valid` drops to 0 and no stale response emerges after `rst` deasserts. Writes are not accepted while `rst`=1.
- Counters and `err_oob` update at the same edge as the request.

## Test plan
- **Reset:** pulse `rst` asynchronously between edges → all outputs 0 immediately. Contents written before reset read back unchanged afterward.
- **Write then read, `RD_LAT`=1:** write 0xDEADBEEF to 0xF040 at edge 0; read 0xF040 at edge 2 → `rd_data`=0xDEADBEEF with `dram_valid`=1 in the cycle after edge 2. Expect `wr_cnt`=1, `rd_cnt`=1.
- **Same-cycle bypass:** `mem[5]`=7. At one edge write 9 to 5 and read 5 → response 9. A read of 5 at the preceding edge → response 7.
- **Streaming, `RD_LAT`=3:** 16 back-to-back reads of 0x20000..0x2000F, preloaded with values 0..15 → `dram_valid` high for exactly 16 consecutive cycles, starting 3 cycles after the first request, with data 0..15 in order.
- **Out of range, `MEM_WORDS`=1024:** read 1024 → response 0 and `err_oob`=1. A write to 2000 leaves memory untouched. `err_oob` stays 1 until `rst`.
- **Mid-burst reset, `RD_LAT`=4:** issue 4 reads, assert `rst` after 2 cycles, release it → no `dram_valid` pulse is ever produced for those reads. Counters read 0 after release.
